mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single synchronous system memory between the CPU datapath (port C) and a DMA/loader (port D).
// - Sits between the control-unit-driven MA/MD transfers and the memory macro.
// - Arbitrates, latches the request, sequences one memory access, then returns read data plus a one-cycle ack.
// PARAMETERS
// - ADDR_W  8  memory address width (bits)
// - DATA_W  8  memory data width (bits)
// PORTS
// - i_clk          in   1       system clock, rising edge
// - i_rstn         in   1       asynchronous active-low reset
// - i_c_req        in   1       CPU request, level; hold until o_c_ack
// - i_c_we         in   1       CPU write (1) / read (0)
// - i_c_addr       in   ADDR_W  CPU address
// - i_c_wdata      in   DATA_W  CPU write data
// - o_c_ack        out  1       CPU transaction complete, 1-cycle pulse
// - o_c_rdata      out  DATA_W  CPU read data, registered, held until next CPU read
// - i_d_req/i_d_we/i_d_addr/i_d_wdata, o_d_ack/o_d_rdata   DMA port, same widths and rules as the CPU port
// - o_mem_en       out  1       memory enable
// - o_mem_we       out  1       memory write enable
// - o_mem_addr     out  ADDR_W  memory address
// - o_mem_wdata    out  DATA_W  memory write data
// - i_mem_rdata    in   DATA_W  memory read data, valid 1 cycle after o_mem_en
// - o_busy         out  1       transaction in flight (state != IDLE)
// - o_owner        out  1       0 = CPU, 1 = DMA; current/last granted port
// BEHAVIOUR
// - Reset values: state IDLE. All outputs 0: acks, rdata regs, mem_* outputs, o_busy, o_owner. last_owner = DMA.
// - FSM, 4 states:
//   - IDLE -> ISSUE when any req = 1. The winner's we/addr/wdata are latched into internal regs. The owner is registered.
//   - ISSUE: o_mem_en = 1; o_mem_we = latched we; mem addr/wdata driven from the latches. Always -> CAPTURE.
//   - CAPTURE: on a read, the owner's rdata reg <= i_mem_rdata. On a write, rdata is unchanged. Always -> ACK.
//   - ACK: the owner's ack = 1 for exactly this cycle; last_owner <= owner. Always -> IDLE.
// - Outside ISSUE, o_mem_en = o_mem_we = 0. mem addr/wdata hold the latched values (don't-care for the memory).
// - Latency: req seen in IDLE at cycle N -> ack at cycle N+3. Max throughput is 1 access per 4 cycles.
// - Arbitration: round-robin on simultaneous requests; the port != last_owner wins. After reset the CPU wins first.
// - A single requester always wins immediately.
// - Handshake: req is sampled only in IDLE. Inputs may change after latching without effect.
// - A req still high in the IDLE after ack is a NEW transaction. A requester must drop req in its ack cycle to avoid a repeat.
// - Req dropped mid-transaction: the access still completes and ack still pulses (no abort).
// - Loser's req stays pending; it is granted in the very next IDLE (no starvation).
// - Reset mid-transaction: immediate return to reset values. No ack and no write strobe after reset asserts. A partial write cannot occur: the strobe is a single ISSUE cycle.
// - The other port's ack and rdata are never touched by a transaction it does not own.
// CONFIGURATION
// - MEM_ARB_FIXED_PRIO_EN defined: fixed priority. The CPU always wins simultaneous requests; last_owner is ignored. The DMA may starve while the CPU keeps req high.
// - MEM_ARB_FIXED_PRIO_EN undefined (default): round-robin as above.
// TESTING
// - CPU-only read: mem[0x10] = 0xA5, c_req/addr = 0x10 at cycle 0 -> mem_en cycle 1, o_c_ack cycle 3, o_c_rdata = 0xA5, d_ack stays 0.
// - DMA write: d_we = 1, addr 0x20, wdata 0x3C -> exactly one cycle with mem_en = mem_we = 1, addr 0x20, wdata 0x3C. o_d_ack 2 cycles later. A CPU read of 0x20 then returns 0x3C.
// - Simultaneous reqs held after reset: grant order C, D, C, D. o_owner is 0, 1, 0, 1 in the ISSUE cycles. Each ack is 4 cycles apart.
// - With MEM_ARB_FIXED_PRIO_EN, both reqs held high for 3 transactions -> 3 CPU acks, 0 DMA acks. Drop c_req -> DMA granted next IDLE.
// - Reset pulse during CAPTURE of a CPU read -> no o_c_ack. o_c_rdata = 0, o_busy = 0. The first request after release is granted CPU-first.
// - c_req dropped in the ISSUE cycle -> o_c_ack still pulses at N+3, followed by no further transaction.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory between the CPU port (C) and the
// DMA/loader port (D). One access per grant: latch, issue, capture, ack.
// Optional build macro MEM_ARB_FIXED_PRIO_EN: CPU always wins simultaneous
// requests. Default (undefined): round-robin against the last owner.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for a request; winner latched on exit
// S_ISSUE   | memory strobe cycle (en, and we for writes)
// S_CAPTURE | memory read data valid; loaded into the owner's rdata reg
// S_ACK     | owner's ack high for this cycle; last_owner updated
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_c_req,
  input  logic              i_c_we,
  input  logic [ADDR_W-1:0] i_c_addr,
  input  logic [DATA_W-1:0] i_c_wdata,
  output logic              o_c_ack,
  output logic [DATA_W-1:0] o_c_rdata,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic              o_d_ack,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_owner
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t state;
  logic   last_owner;  // 0 = CPU, 1 = DMA; resets to DMA so the CPU wins first
  logic   lat_we;
  logic   grant;       // winner of the current IDLE cycle, 0 = CPU, 1 = DMA

  // Pick the winner among the requests present this cycle.
  always_comb begin
    grant = 1'b0;
    if (i_c_req && i_d_req) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant = 1'b0;
`else
      grant = ~last_owner;
`endif
    end else if (i_d_req) begin
      grant = 1'b1;
    end
  end

  // Access sequencer; every output is a register so the memory sees clean strobes.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      last_owner  <= 1'b1;
      lat_we      <= 1'b0;
      o_owner     <= 1'b0;
      o_busy      <= 1'b0;
      o_c_ack     <= 1'b0;
      o_d_ack     <= 1'b0;
      o_c_rdata   <= '0;
      o_d_rdata   <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      o_c_ack <= 1'b0;
      o_d_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_c_req || i_d_req) begin
            state       <= S_ISSUE;
            o_owner     <= grant;
            o_busy      <= 1'b1;
            o_mem_en    <= 1'b1;
            lat_we      <= grant ? i_d_we    : i_c_we;
            o_mem_we    <= grant ? i_d_we    : i_c_we;
            o_mem_addr  <= grant ? i_d_addr  : i_c_addr;
            o_mem_wdata <= grant ? i_d_wdata : i_c_wdata;
          end
        end
        S_ISSUE: begin
          // Strobe lasts exactly one cycle; addr/wdata simply hold.
          o_mem_en <= 1'b0;
          o_mem_we <= 1'b0;
          state    <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (!lat_we) begin
            if (o_owner) o_d_rdata <= i_mem_rdata;
            else         o_c_rdata <= i_mem_rdata;
          end
          if (o_owner) o_d_ack <= 1'b1;
          else         o_c_ack <= 1'b1;
          state <= S_ACK;
        end
        S_ACK: begin
          last_owner <= o_owner;
          o_busy     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a behavioural
// synchronous memory. Inputs change and outputs are sampled 1 ns after posedge.
module tb_mem_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_c_req, i_c_we, i_d_req, i_d_we;
  logic [7:0] i_c_addr, i_c_wdata, i_d_addr, i_d_wdata;
  logic       o_c_ack, o_d_ack;
  logic [7:0] o_c_rdata, o_d_rdata;
  logic       o_mem_en, o_mem_we;
  logic [7:0] o_mem_addr, o_mem_wdata;
  logic [7:0] i_mem_rdata = 8'h00;
  logic       o_busy, o_owner;

  logic [7:0] mem [0:255];
  int         total = 0;
  int         bad   = 0;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_c_req(i_c_req), .i_c_we(i_c_we), .i_c_addr(i_c_addr), .i_c_wdata(i_c_wdata),
    .o_c_ack(o_c_ack), .o_c_rdata(o_c_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
    .o_d_ack(o_d_ack), .o_d_rdata(o_d_rdata),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_owner(o_owner)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous memory: read data valid the cycle after the enable.
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
      i_mem_rdata <= mem[o_mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Called in the IDLE cycle where the request is presented; returns in the
  // IDLE cycle after the ack. drop clears both requests during ISSUE.
  task automatic expect_txn(input string tag, input logic own, input logic we,
                            input logic [7:0] addr, input logic [7:0] wdata,
                            input logic [7:0] rdata, input logic drop);
    tick();
    check({tag, "_issue_en"},   o_mem_en,   1);
    check({tag, "_issue_we"},   o_mem_we,   we);
    check({tag, "_issue_addr"}, o_mem_addr, addr);
    if (we) check({tag, "_issue_wdata"}, o_mem_wdata, wdata);
    check({tag, "_owner"},      o_owner,    own);
    check({tag, "_busy"},       o_busy,     1);
    if (drop) begin
      i_c_req = 1'b0;
      i_d_req = 1'b0;
    end
    tick();
    check({tag, "_capture_en"}, o_mem_en, 0);
    check({tag, "_capture_ack"}, {o_c_ack, o_d_ack}, 0);
    tick();
    check({tag, "_c_ack"}, o_c_ack, !own);
    check({tag, "_d_ack"}, o_d_ack, own);
    if (!we) check({tag, "_rdata"}, own ? o_d_rdata : o_c_rdata, rdata);
    tick();
    check({tag, "_ack_done"}, {o_c_ack, o_d_ack}, 0);
    check({tag, "_idle_busy"}, o_busy, 0);
  endtask

  initial begin
    logic exp_own;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hA5;
    i_rstn = 1'b0;
    i_c_req = 0; i_c_we = 0; i_c_addr = 0; i_c_wdata = 0;
    i_d_req = 0; i_d_we = 0; i_d_addr = 0; i_d_wdata = 0;
    tick(); tick();
    check("rst_outs", {o_c_ack, o_d_ack, o_mem_en, o_mem_we, o_busy, o_owner}, 0);
    check("rst_rdata", {o_c_rdata, o_d_rdata}, 0);
    check("rst_mem_bus", {o_mem_addr, o_mem_wdata}, 0);
    i_rstn = 1'b1;
    tick();

    // CPU-only read, req dropped in the ISSUE cycle.
    i_c_req = 1; i_c_we = 0; i_c_addr = 8'h10;
    check("c0_idle_en", o_mem_en, 0);
    expect_txn("cread", 0, 0, 8'h10, 8'h00, 8'hA5, 1);
    check("cread_d_rdata", o_d_rdata, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_repeat", {o_busy, o_mem_en, o_c_ack}, 0);
    end

    // DMA write, then CPU reads it back.
    i_d_req = 1; i_d_we = 1; i_d_addr = 8'h20; i_d_wdata = 8'h3C;
    expect_txn("dwrite", 1, 1, 8'h20, 8'h3C, 8'h00, 1);
    check("dwrite_d_rdata", o_d_rdata, 0);
    check("dwrite_c_rdata", o_c_rdata, 8'hA5);
    i_c_req = 1; i_c_we = 0; i_c_addr = 8'h20;
    expect_txn("readback", 0, 0, 8'h20, 8'h00, 8'h3C, 1);

    // Reset during CAPTURE of a CPU read.
    i_c_req = 1; i_c_addr = 8'h10;
    tick();
    tick();
    #2 i_rstn = 1'b0;
    #1;
    check("mid_rst_rdata", o_c_rdata, 0);
    check("mid_rst_busy",  o_busy, 0);
    check("mid_rst_en",    o_mem_en, 0);
    i_c_req = 0;
    tick();
    check("mid_rst_noack", {o_c_ack, o_d_ack}, 0);
    i_rstn = 1'b1;
    tick();

    // Both held after reset: CPU first, then alternate (fixed build: CPU only).
    i_c_req = 1; i_c_we = 0; i_c_addr = 8'h10;
    i_d_req = 1; i_d_we = 0; i_d_addr = 8'h20;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      exp_own = 1'b0;
`else
      exp_own = i[0];
`endif
      expect_txn("both", exp_own, 0, exp_own ? 8'h20 : 8'h10, 8'h00,
                 exp_own ? 8'h3C : 8'hA5, 0);
    end
`ifdef MEM_ARB_FIXED_PRIO_EN
    i_c_req = 0;
    expect_txn("fixed_d", 1, 0, 8'h20, 8'h00, 8'h3C, 1);
`endif
    i_c_req = 0; i_d_req = 0;
    tick();
    check("final_idle", o_busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
